// File: rtl/timer_counter_ctrl.sv
// Prescaled up/down timer with sticky overflow/underflow flags and IRQ.
// Optional build macro TIMER_AUTO_RELOAD_EN: wraps reload TDR_IN.
module timer_counter_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             EN_IN,
    input  logic             DIR_IN,
    input  logic [1:0]       CLK_SEL_IN,
    input  logic             LOAD_IN,
    input  logic [WIDTH-1:0] TDR_IN,
    input  logic [1:0]       CLR_IN,
    input  logic [1:0]       IE_IN,
    output logic [WIDTH-1:0] TCNT_OUT,
    output logic [1:0]       TSR_OUT,
    output logic             IRQ_OUT
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] MAXV = '1;

    logic [3:0]       presc;
    logic [3:0]       div_m1;
    logic             tick;
    logic             at_max;
    logic             at_min;
    logic             ovf_evt;
    logic             undf_evt;
    logic [WIDTH-1:0] wrap_up;
    logic [WIDTH-1:0] wrap_dn;

    // Terminal prescaler count for the selected divisor
    always_comb begin
        div_m1 = 4'd1;
        case (CLK_SEL_IN)
            2'd0:    div_m1 = 4'd1;
            2'd1:    div_m1 = 4'd3;
            2'd2:    div_m1 = 4'd7;
            default: div_m1 = 4'd15;
        endcase
    end

    // >= lets a shrinking divisor fire at once instead of rolling over
    always_comb begin
        tick     = EN_IN && (presc >= div_m1);
        at_max   = (TCNT_OUT == MAXV);
        at_min   = (TCNT_OUT == ZERO);
        ovf_evt  = tick && !LOAD_IN && !DIR_IN && at_max;
        undf_evt = tick && !LOAD_IN &&  DIR_IN && at_min;
`ifdef TIMER_AUTO_RELOAD_EN
        wrap_up  = TDR_IN;
        wrap_dn  = TDR_IN;
`else
        wrap_up  = ZERO;
        wrap_dn  = MAXV;
`endif
    end

    // Prescaler: restarts on reset, load or tick; holds while disabled
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            presc <= 4'd0;
        end else if (LOAD_IN) begin
            presc <= 4'd0;
        end else if (tick) begin
            presc <= 4'd0;
        end else if (EN_IN) begin
            presc <= presc + 4'd1;
        end
    end

    // Counter: load beats tick; wraps go to the build-selected value
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            TCNT_OUT <= ZERO;
        end else if (LOAD_IN) begin
            TCNT_OUT <= TDR_IN;
        end else if (tick) begin
            if (DIR_IN) begin
                TCNT_OUT <= at_min ? wrap_dn : TCNT_OUT - ONE;
            end else begin
                TCNT_OUT <= at_max ? wrap_up : TCNT_OUT + ONE;
            end
        end
    end

    // Sticky flags: clear by strobe, a same-cycle set wins
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            TSR_OUT <= 2'b00;
        end else begin
            TSR_OUT <= (TSR_OUT & ~CLR_IN) | {undf_evt, ovf_evt};
        end
    end

    // Interrupt straight from the registered flags
    always_comb begin
        IRQ_OUT = |(TSR_OUT & IE_IN);
    end

endmodule

// File: tb/tb_timer_counter_ctrl.sv
// Scoreboarded random and directed test of timer_counter_ctrl.
// Reference model tracks count and prescale phase arithmetically.
module tb_timer_counter_ctrl;

    localparam int W = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         PCLK = 1'b0;
    logic         PRESET = 1'b0;
    logic         EN_IN = 1'b0;
    logic         DIR_IN = 1'b0;
    logic [1:0]   CLK_SEL_IN = 2'd0;
    logic         LOAD_IN = 1'b0;
    logic [W-1:0] TDR_IN = '0;
    logic [1:0]   CLR_IN = 2'b00;
    logic [1:0]   IE_IN = 2'b00;
    logic [W-1:0] TCNT_OUT;
    logic [1:0]   TSR_OUT;
    logic         IRQ_OUT;

    typedef struct {
        int       cnt;
        bit [1:0] tsr;
        bit       irq;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;

    int       m_cnt = 0;
    int       m_ph = 0;
    bit [1:0] m_tsr = 2'b00;

    timer_counter_ctrl #(.WIDTH(W)) dut (
        .PCLK(PCLK),
        .PRESET(PRESET),
        .EN_IN(EN_IN),
        .DIR_IN(DIR_IN),
        .CLK_SEL_IN(CLK_SEL_IN),
        .LOAD_IN(LOAD_IN),
        .TDR_IN(TDR_IN),
        .CLR_IN(CLR_IN),
        .IE_IN(IE_IN),
        .TCNT_OUT(TCNT_OUT),
        .TSR_OUT(TSR_OUT),
        .IRQ_OUT(IRQ_OUT)
    );

    always #5 PCLK = ~PCLK;

    // Drive one cycle of inputs and queue the state expected after the edge
    task automatic step(input bit rst, input bit en, input bit dir,
                        input bit [1:0] sel, input bit ld,
                        input bit [W-1:0] tdr, input bit [1:0] clr,
                        input bit [1:0] ie);
        int       div;
        bit [1:0] set;
        exp_t     e;
        @(negedge PCLK);
        PRESET = rst; EN_IN = en; DIR_IN = dir; CLK_SEL_IN = sel;
        LOAD_IN = ld; TDR_IN = tdr; CLR_IN = clr; IE_IN = ie;
        div = 2 << sel;
        set = 2'b00;
        if (rst) begin
            m_cnt = 0; m_ph = 0; m_tsr = 2'b00;
        end else if (ld) begin
            m_cnt = int'(tdr); m_ph = 0; m_tsr = m_tsr & ~clr;
        end else begin
            if (en) begin
                if (m_ph + 1 >= div) begin
                    m_ph = 0;
                    if (!dir) begin
                        if (m_cnt == MAXV) begin
                            set[0] = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                            m_cnt = int'(tdr);
`else
                            m_cnt = 0;
`endif
                        end else m_cnt = m_cnt + 1;
                    end else begin
                        if (m_cnt == 0) begin
                            set[1] = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                            m_cnt = int'(tdr);
`else
                            m_cnt = MAXV;
`endif
                        end else m_cnt = m_cnt - 1;
                    end
                end else m_ph = m_ph + 1;
            end
            m_tsr = (m_tsr & ~clr) | set;
        end
        e.cnt = m_cnt;
        e.tsr = m_tsr;
        e.irq = |(m_tsr & ie);
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Sample just after the edge the queued transaction applies to
    task automatic settle();
        @(posedge PCLK);
        #2;
    endtask

    // Monitor: pops one expectation per clock edge that has one pending
    always @(posedge PCLK) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (int'(TCNT_OUT) == e.cnt && TSR_OUT == e.tsr &&
                IRQ_OUT == e.irq) begin
                passed++;
            end else begin
                $display("FAIL sb t=%0t: tcnt/tsr/irq got %0h/%b/%b expected %0h/%b/%b",
                         $time, TCNT_OUT, TSR_OUT, IRQ_OUT, e.cnt, e.tsr, e.irq);
            end
        end
    end

    initial begin
        // Free-run up count at divisor 2
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 512; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("run512_tcnt", int'(TCNT_OUT), 0);
        chk("run512_tsr", int'(TSR_OUT), 1);

        // Overflow from FE with interrupt, then clear
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 8'hFE, 0, 2'b01);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 8'hFE, 0, 2'b01);
        settle();
        chk("ovf_tsr", int'(TSR_OUT), 1);
        chk("ovf_irq", int'(IRQ_OUT), 1);
        step(0, 0, 0, 0, 0, 8'hFE, 2'b01, 2'b01);
        settle();
        chk("clr_tsr", int'(TSR_OUT), 0);
        chk("clr_irq", int'(IRQ_OUT), 0);

        // Underflow from 01 counting down, divisor 4
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 1, 8'h01, 0, 2'b10);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 1, 0, 8'h01, 0, 2'b10);
        settle();
`ifdef TIMER_AUTO_RELOAD_EN
        chk("undf_tcnt", int'(TCNT_OUT), 8'h01);
`else
        chk("undf_tcnt", int'(TCNT_OUT), 8'hFF);
`endif
        chk("undf_tsr", int'(TSR_OUT), 2);
        chk("undf_irq", int'(IRQ_OUT), 1);

        // Clear coinciding with overflow tick: set wins
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 8'hFF, 0, 0);
        step(0, 1, 0, 0, 0, 8'hFF, 0, 0);
        step(0, 1, 0, 0, 0, 8'hFF, 2'b01, 0);
        settle();
        chk("setwins_tsr", int'(TSR_OUT), 1);

        // Enable hold, then reset pulse with load ignored
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("hold_tcnt", int'(TCNT_OUT), 2);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("hold_resume", int'(TCNT_OUT), 3);
        step(1, 1, 0, 0, 1, 8'h55, 0, 0);
        settle();
        chk("rst_tcnt", int'(TCNT_OUT), 0);
        chk("rst_tsr", int'(TSR_OUT), 0);

        // Divisor shrink 16 -> 2 at prescaler 9
        for (int i = 0; i < 9; i++) step(0, 1, 0, 3, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("sel_first_tick", int'(TCNT_OUT), 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("sel_next_tick", int'(TCNT_OUT), 2);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit rst, en, dir, ld;
            bit [1:0] sel, clr, ie;
            bit [W-1:0] tdr;
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            dir = ($urandom_range(0, 63) == 0) ? ~DIR_IN : DIR_IN;
            sel = ($urandom_range(0, 31) == 0) ? 2'($urandom) : CLK_SEL_IN;
            ld  = ($urandom_range(0, 99) == 0);
            tdr = W'($urandom);
            clr = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            ie  = 2'($urandom);
            step(rst, en, dir, sel, ld, tdr, clr, ie);
        end

        repeat (3) @(posedge PCLK);
        #3;
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/timer_counter_ctrl.md
TIMER_COUNTER_CTRL -- requirements
Module: timer_counter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and reload width in bits (legal range 2..32).
REQ-002 SHALL have one clock and a synchronous, active-high reset: PCLK and PRESET.
REQ-003 SHALL have port PCLK  input  1  rising-edge clock for all state.
REQ-004 SHALL have port PRESET  input  1  synchronous active-high reset, sampled on PCLK rising edge.
REQ-005 SHALL have port EN_IN  input  1  count enable; 0 freezes prescaler and counter.
REQ-006 SHALL have port DIR_IN  input  1  count direction; 0 = up, 1 = down.
REQ-007 SHALL have port CLK_SEL_IN  input  2  prescaler select; divisor = 2 << CLK_SEL_IN (2, 4, 8, 16).
REQ-008 SHALL have port LOAD_IN  input  1  single-cycle load of TDR_IN into counter.
REQ-009 SHALL have port TDR_IN  input  WIDTH  load/reload value.
REQ-010 SHALL have port CLR_IN  input  2  write-1-to-clear strobe; bit0 clears OVF, bit1 clears UNDF.
REQ-011 SHALL have port IE_IN  input  2  interrupt enable; bit0 for OVF, bit1 for UNDF.
REQ-012 SHALL have port TCNT_OUT  output  WIDTH  current counter value, registered.
REQ-013 SHALL have port TSR_OUT  output  2  sticky status; bit0 OVF, bit1 UNDF, registered.
REQ-014 SHALL have port IRQ_OUT  output  1  |(TSR_OUT & IE_IN), combinational from registered flags.

Function
REQ-015 Prescaler SHALL be a 4-bit counter advancing once per PCLK while EN_IN=1; tick asserted in the cycle its value >= divisor-1, and it returns to 0 on the same edge.
REQ-016 Using >= SHALL ensure a CLK_SEL_IN change to a smaller divisor mid-count produces a tick on the next enabled cycle, with no 16-cycle stall.
REQ-017 On tick with DIR_IN=0: TCNT<=TCNT+1; at TCNT=2^WIDTH-1, TCNT wraps (REQ-026) and TSR_OUT[0] sets on the same edge.
REQ-018 On tick with DIR_IN=1: TCNT<=TCNT-1; at TCNT=0, TCNT wraps (REQ-026) and TSR_OUT[1] sets on the same edge.
REQ-019 LOAD_IN=1 SHALL load TCNT<=TDR_IN and clear the prescaler on the next edge, regardless of EN_IN; it has priority over a tick, and sets no flag that cycle.
REQ-020 CLR_IN bit SHALL clear the corresponding TSR_OUT bit on the next edge; when set and clear coincide in one cycle, set wins.
REQ-021 Flags SHALL be sticky; repeated wraps leave a set flag at 1; no flag auto-clears.
REQ-022 DIR_IN change SHALL take effect on the next tick; the prescaler phase is unaffected.
REQ-023 Counter latency: TCNT_OUT reflects each tick on the PCLK edge ending the tick cycle; IRQ_OUT follows TSR_OUT with zero added cycles.

Reset
REQ-024 PRESET=1 SHALL on the next edge force TCNT_OUT=0, prescaler=0, TSR_OUT=2'b00, and hence IRQ_OUT=0; it has priority over LOAD_IN, tick and CLR_IN.
REQ-025 Reset asserted mid-count SHALL discard the prescaler phase; the first tick after release occurs divisor cycles after EN_IN=1 is seen.

Configuration
REQ-026 Macro TIMER_AUTO_RELOAD_EN: when defined, overflow/underflow SHALL load TCNT<=TDR_IN; when undefined, up-wrap goes to 0 and down-wrap to 2^WIDTH-1. Flag behaviour is identical in both builds.

Verification (WIDTH=8)
REQ-027 Reset, EN=1, DIR=0, SEL=0 -> TCNT increments every 2 PCLK; after 512 cycles TCNT=8'h00, TSR_OUT=2'b01.
REQ-028 LOAD TDR=8'hFE, SEL=0, up, IE=2'b01 -> OVF and IRQ_OUT=1 4 cycles later; CLR_IN=2'b01 -> TSR_OUT=00 and IRQ_OUT=0 next edge.
REQ-029 LOAD TDR=8'h01, DIR=1, SEL=1 -> UNDF after 8 cycles; TCNT=8'hFF without macro, 8'h01 with TIMER_AUTO_RELOAD_EN.
REQ-030 CLR_IN=2'b01 in same cycle as overflow tick -> TSR_OUT[0] stays 1.
REQ-031 EN=0 mid-count for 10 cycles -> TCNT and prescaler hold; PRESET pulse mid-count -> TCNT=0 and TSR=0 next edge, LOAD_IN ignored that cycle.
REQ-032 SEL changed 3->0 when prescaler=9 -> tick on next enabled cycle, then ticks every 2 cycles.
